// File: rtl/fnd_scan_controller.sv
// Scan controller for a 4-digit common-anode FND: per-digit slot timing, blanking
// dead-time, PWM dimming, per-frame value latch and active-low pin drive.
module fnd_scan_controller #(
    parameter int SCAN_DIV   = 100_000,
    parameter int BLANK_CYC  = 1_000,
    parameter int DIM_ON_CYC = 25_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_lzs,
    input  logic        i_blank,
    input  logic        i_SW_FndLight,
    output logic [3:0]  o_digitPosition,
    output logic [7:0]  o_fndFont,
    output logic        o_frame_done
);

    localparam int CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIM_END = (BLANK_CYC + DIM_ON_CYC > SCAN_DIV) ? SCAN_DIV : BLANK_CYC + DIM_ON_CYC;
    localparam logic [CW:0] L_LAST  = (CW+1)'(SCAN_DIV - 1);
    localparam logic [CW:0] L_SCAN  = (CW+1)'(SCAN_DIV);
    localparam logic [CW:0] L_BLANK = (CW+1)'(BLANK_CYC);
    localparam logic [CW:0] L_DIM   = (CW+1)'(DIM_END);

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_val;
    logic [3:0]    r_dp;

    logic [CW:0]   w_cnt_ext;
    logic          w_last;
    logic          w_frame_start;
    logic [CW:0]   w_on_end;
    phase_t        w_phase;
    logic [15:0]   w_cur_val;
    logic [3:0]    w_cur_dp;
    logic [3:0]    w_nib;
    logic          w_dp_bit;
    logic          w_suppress;
    logic [3:0]    w_dig_next;
    logic [7:0]    w_font_next;

    function automatic logic [7:0] f_font(input logic [3:0] d);
        case (d)
            4'h0: f_font = 8'hC0;  4'h1: f_font = 8'hF9;
            4'h2: f_font = 8'hA4;  4'h3: f_font = 8'hB0;
            4'h4: f_font = 8'h99;  4'h5: f_font = 8'h92;
            4'h6: f_font = 8'h82;  4'h7: f_font = 8'hF8;
            4'h8: f_font = 8'h80;  4'h9: f_font = 8'h90;
            4'hA: f_font = 8'h88;  4'hB: f_font = 8'h83;
            4'hC: f_font = 8'hC6;  4'hD: f_font = 8'hA1;
            4'hE: f_font = 8'h86;  default: f_font = 8'h8E;
        endcase
    endfunction

    assign w_cnt_ext     = {1'b0, r_cnt};
    assign w_last        = (w_cnt_ext == L_LAST);
    assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);

    // Slot/digit sequencing and frame latch; runs regardless of blanking.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_val <= 16'h0000;
            r_dp  <= 4'h0;
        end else begin
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_frame_start) begin
                r_val <= i_value;
                r_dp  <= i_dp;
            end
        end
    end

    // Phase decode; the dimming switch acts within the current slot.
    always_comb begin
        w_on_end = i_SW_FndLight ? L_DIM : L_SCAN;
        if (w_cnt_ext < L_BLANK)
            w_phase = PH_BLANK;
        else if (w_cnt_ext < w_on_end)
            w_phase = PH_ON;
        else
            w_phase = PH_OFF;
    end

    // On the frame-start cycle the latch is being loaded, so bypass it so a
    // zero-blank configuration already shows the new frame's digit 0.
    always_comb begin
        w_cur_val   = w_frame_start ? i_value : r_val;
        w_cur_dp    = w_frame_start ? i_dp : r_dp;
        w_nib       = w_cur_val[{r_idx, 2'b00} +: 4];
        w_dp_bit    = w_cur_dp[r_idx];
        w_suppress  = i_lzs && (r_idx != 2'd0) && ((w_cur_val >> {r_idx, 2'b00}) == 16'h0000);
        w_dig_next  = 4'b1111;
        w_font_next = 8'hFF;
        if (w_phase == PH_ON && !i_blank) begin
            if (!w_suppress) begin
                w_dig_next  = ~(4'b0001 << r_idx);
                w_font_next = f_font(w_nib) & {~w_dp_bit, 7'h7F};
            end else if (w_dp_bit) begin
                w_dig_next  = ~(4'b0001 << r_idx);
                w_font_next = 8'h7F;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_digitPosition <= 4'b1111;
            o_fndFont       <= 8'hFF;
            o_frame_done    <= 1'b0;
        end else begin
            o_digitPosition <= w_dig_next;
            o_fndFont       <= w_font_next;
            o_frame_done    <= w_frame_start;
        end
    end

endmodule
